// File: rtl/kmu_cta_dispatch.sv
// kmu_cta_dispatch
//   Accepts one kernel launch and walks its CTA grid x-fastest, then y, then z.
//   It issues at most one CTA per cycle over a valid/ready channel. CTAs go
//   round-robin to the cores that are enabled for the kernel.
//
// Ports
//   clk, reset            single clock; asynchronous active-high reset
//   launch_*              launch request (valid/ready) and kernel fields
//   abort                 cancels the kernel that is being dispatched
//   cta_valid[NUM_CORES]  one-hot target core for the current CTA
//   cta_ready[NUM_CORES]  per-core accept
//   cta_*                 latched kernel fields and the current CTA coordinates/id
//   busy                  high whenever the dispatcher is not idle
//   done                  one-cycle pulse once every CTA has been accepted
module kmu_cta_dispatch #(
    parameter int NUM_CORES   = 4,
    parameter int XLEN        = 32,
    parameter int NUM_THREADS = 4,
    parameter int DIM_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   launch_valid,
    output logic                   launch_ready,
    input  logic [31:0]            launch_num_warps,
    input  logic [XLEN-1:0]        launch_start_pc,
    input  logic [XLEN-1:0]        launch_param,
    input  logic [DIM_W-1:0]       launch_grid_x,
    input  logic [DIM_W-1:0]       launch_grid_y,
    input  logic [DIM_W-1:0]       launch_grid_z,
    input  logic [NUM_THREADS-1:0] launch_remain_mask,
    input  logic [NUM_CORES-1:0]   launch_core_mask,

    input  logic                   abort,

    output logic [NUM_CORES-1:0]   cta_valid,
    input  logic [NUM_CORES-1:0]   cta_ready,
    output logic [31:0]            cta_num_warps,
    output logic [XLEN-1:0]        cta_start_pc,
    output logic [XLEN-1:0]        cta_param,
    output logic [NUM_THREADS-1:0] cta_remain_mask,
    output logic [DIM_W-1:0]       cta_x,
    output logic [DIM_W-1:0]       cta_y,
    output logic [DIM_W-1:0]       cta_z,
    output logic [31:0]            cta_id,

    output logic                   busy,
    output logic                   done
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        FINISH
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;     // core that accepted the most recent CTA
    logic [PTR_W-1:0]       target;     // core that cta_valid currently points at
    logic [NUM_CORES-1:0]   core_mask;
    logic [DIM_W-1:0]       grid_x;
    logic [DIM_W-1:0]       grid_y;
    logic [DIM_W-1:0]       grid_z;

    logic [NUM_CORES-1:0]   launch_mask_eff;
    logic                   launch_fire;
    logic                   launch_empty;
    logic                   cta_fire;
    logic                   x_last;
    logic                   y_last;
    logic                   z_last;

    // Finds the first enabled core strictly after ptr, wrapping around.
    // If ptr is the only enabled core, ptr itself is returned.
    function automatic logic [PTR_W-1:0] next_core(
        input logic [NUM_CORES-1:0] mask,
        input logic [PTR_W-1:0]     ptr
    );
        logic [PTR_W-1:0] sel;
        logic [PTR_W-1:0] idx_w;
        logic             found;
        int unsigned      idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_CORES; i++) begin
            idx   = (32'(ptr) + i) % NUM_CORES;
            idx_w = PTR_W'(idx);
            if (!found && mask[idx_w]) begin
                sel   = idx_w;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [NUM_CORES-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_CORES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // An empty core mask means that every core is eligible.
    assign launch_mask_eff = (launch_core_mask == '0) ? '1 : launch_core_mask;
    assign launch_ready    = (state == IDLE);
    assign busy            = (state != IDLE);
    assign launch_fire     = launch_valid && launch_ready;
    assign launch_empty    = (launch_grid_x == '0) || (launch_grid_y == '0) ||
                             (launch_grid_z == '0);

    // cta_valid is one-hot, so a hit on any bit is a hit on the targeted core.
    assign cta_fire = (state == DISPATCH) && (|(cta_valid & cta_ready));
    assign x_last   = (cta_x == grid_x - DIM_W'(1));
    assign y_last   = (cta_y == grid_y - DIM_W'(1));
    assign z_last   = (cta_z == grid_z - DIM_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rr_ptr          <= PTR_W'(NUM_CORES - 1);
            target          <= '0;
            core_mask       <= '0;
            grid_x          <= '0;
            grid_y          <= '0;
            grid_z          <= '0;
            cta_valid       <= '0;
            cta_num_warps   <= '0;
            cta_start_pc    <= '0;
            cta_param       <= '0;
            cta_remain_mask <= '0;
            cta_x           <= '0;
            cta_y           <= '0;
            cta_z           <= '0;
            cta_id          <= '0;
            done            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (launch_fire) begin
                        core_mask       <= launch_mask_eff;
                        grid_x          <= launch_grid_x;
                        grid_y          <= launch_grid_y;
                        grid_z          <= launch_grid_z;
                        cta_num_warps   <= launch_num_warps;
                        cta_start_pc    <= launch_start_pc;
                        cta_param       <= launch_param;
                        cta_remain_mask <= launch_remain_mask;
                        cta_x           <= '0;
                        cta_y           <= '0;
                        cta_z           <= '0;
                        cta_id          <= '0;
                        if (launch_empty) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state     <= DISPATCH;
                            target    <= next_core(launch_mask_eff, rr_ptr);
                            cta_valid <= onehot(next_core(launch_mask_eff, rr_ptr));
                        end
                    end
                end

                DISPATCH: begin
                    if (cta_fire) begin
                        rr_ptr <= target;
                    end
                    if (abort) begin
                        // A handshake in this same cycle has already reached the
                        // core, so the only thing left is to stop issuing CTAs.
                        state     <= IDLE;
                        cta_valid <= '0;
                    end else if (cta_fire) begin
                        if (x_last && y_last && z_last) begin
                            state     <= FINISH;
                            cta_valid <= '0;
                            done      <= 1'b1;
                        end else begin
                            if (x_last) begin
                                cta_x <= '0;
                                if (y_last) begin
                                    cta_y <= '0;
                                    cta_z <= cta_z + DIM_W'(1);
                                end else begin
                                    cta_y <= cta_y + DIM_W'(1);
                                end
                            end else begin
                                cta_x <= cta_x + DIM_W'(1);
                            end
                            cta_id    <= cta_id + 32'd1;
                            target    <= next_core(core_mask, target);
                            cta_valid <= onehot(next_core(core_mask, target));
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    cta_valid <= '0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // At most one core is ever targeted.
    a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(cta_valid));

    // An offered CTA holds its target and its coordinates until it is taken.
    a_hold: assert property (@(posedge clk) disable iff (reset)
        ((|(cta_valid & ~cta_ready)) && !abort) |=>
            ($stable(cta_valid) && $stable(cta_id) && $stable(cta_x)));

endmodule

// File: tb/tb_kmu_cta_dispatch.sv
// tb_kmu_cta_dispatch
//   Directed bench for kmu_cta_dispatch. A vector table holds whole kernels
//   with every core ready, together with the hand-derived core order for each.
//   Hand-written sequences cover stalls, abort, a mid-kernel reset and a launch
//   that is held while the dispatcher is busy.
module tb_kmu_cta_dispatch;

    logic        clk;
    logic        reset;
    logic        launch_valid;
    logic        launch_ready;
    logic [31:0] launch_num_warps;
    logic [31:0] launch_start_pc;
    logic [31:0] launch_param;
    logic [15:0] launch_grid_x;
    logic [15:0] launch_grid_y;
    logic [15:0] launch_grid_z;
    logic [3:0]  launch_remain_mask;
    logic [3:0]  launch_core_mask;
    logic        abort;
    logic [3:0]  cta_valid;
    logic [3:0]  cta_ready;
    logic [31:0] cta_num_warps;
    logic [31:0] cta_start_pc;
    logic [31:0] cta_param;
    logic [3:0]  cta_remain_mask;
    logic [15:0] cta_x;
    logic [15:0] cta_y;
    logic [15:0] cta_z;
    logic [31:0] cta_id;
    logic        busy;
    logic        done;

    kmu_cta_dispatch #(
        .NUM_CORES  (4),
        .XLEN       (32),
        .NUM_THREADS(4),
        .DIM_W      (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .launch_valid      (launch_valid),
        .launch_ready      (launch_ready),
        .launch_num_warps  (launch_num_warps),
        .launch_start_pc   (launch_start_pc),
        .launch_param      (launch_param),
        .launch_grid_x     (launch_grid_x),
        .launch_grid_y     (launch_grid_y),
        .launch_grid_z     (launch_grid_z),
        .launch_remain_mask(launch_remain_mask),
        .launch_core_mask  (launch_core_mask),
        .abort             (abort),
        .cta_valid         (cta_valid),
        .cta_ready         (cta_ready),
        .cta_num_warps     (cta_num_warps),
        .cta_start_pc      (cta_start_pc),
        .cta_param         (cta_param),
        .cta_remain_mask   (cta_remain_mask),
        .cta_x             (cta_x),
        .cta_y             (cta_y),
        .cta_z             (cta_z),
        .cta_id            (cta_id),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // cores: expected target index per CTA, element 0 is the first CTA.
    // The concatenations below are written last-CTA-first.
    typedef struct {
        logic [15:0]     gx;
        logic [15:0]     gy;
        logic [15:0]     gz;
        logic [3:0]      mask;
        int              n;
        logic [7:0][1:0] cores;
    } vec_t;

    vec_t vecs[7];

    task automatic apply_reset();
        reset              = 1'b1;
        launch_valid       = 1'b0;
        launch_num_warps   = '0;
        launch_start_pc    = '0;
        launch_param       = '0;
        launch_grid_x      = '0;
        launch_grid_y      = '0;
        launch_grid_z      = '0;
        launch_remain_mask = '0;
        launch_core_mask   = '0;
        abort              = 1'b0;
        cta_ready          = '1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_launch(input logic [15:0] gx, input logic [15:0] gy,
                              input logic [15:0] gz, input logic [3:0] mask,
                              input logic [31:0] param);
        launch_grid_x      = gx;
        launch_grid_y      = gy;
        launch_grid_z      = gz;
        launch_core_mask   = mask;
        launch_param       = param;
        launch_num_warps   = 32'd6;
        launch_start_pc    = 32'h0000_0400;
        launch_remain_mask = 4'b0111;
    endtask

    logic [3:0]  exp_v;
    logic [15:0] mx, my, mz;
    int          hs_cnt;

    initial begin
        vecs[0] = '{16'd2, 16'd2, 16'd1, 4'b1111, 4, {2'd0,2'd0,2'd0,2'd0,2'd3,2'd2,2'd1,2'd0}};
        vecs[1] = '{16'd3, 16'd1, 16'd1, 4'b1010, 3, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd1,2'd3,2'd1}};
        vecs[2] = '{16'd0, 16'd4, 16'd4, 4'b1111, 0, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0}};
        vecs[3] = '{16'd1, 16'd1, 16'd1, 4'b0000, 1, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0}};
        vecs[4] = '{16'd2, 16'd1, 16'd2, 4'b0100, 4, {2'd0,2'd0,2'd0,2'd0,2'd2,2'd2,2'd2,2'd2}};
        vecs[5] = '{16'd3, 16'd2, 16'd1, 4'b0011, 6, {2'd0,2'd0,2'd1,2'd0,2'd1,2'd0,2'd1,2'd0}};
        vecs[6] = '{16'd1, 16'd3, 16'd2, 4'b1001, 6, {2'd0,2'd0,2'd3,2'd0,2'd3,2'd0,2'd3,2'd0}};

        // Reset state, sampled while reset is still asserted.
        reset = 1'b1;
        launch_valid = 1'b0; abort = 1'b0; cta_ready = '1;
        set_launch(16'd0, 16'd0, 16'd0, 4'b0000, 32'd0);
        #2;
        check("rst_launch_ready", launch_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cta_valid", cta_valid, 0);
        check("rst_cta_id", cta_id, 0);

        // Table-driven kernels. Every core is always ready.
        for (int i = 0; i < 7; i++) begin
            apply_reset();
            set_launch(vecs[i].gx, vecs[i].gy, vecs[i].gz, vecs[i].mask, 32'hA000_0000 | 32'(i));
            launch_valid = 1'b1;
            check($sformatf("v%0d_launch_ready", i), launch_ready, 1);
            @(posedge clk); #1;
            launch_valid = 1'b0;
            mx = '0; my = '0; mz = '0;
            for (int k = 0; k < vecs[i].n; k++) begin
                exp_v = 4'b0001 << vecs[i].cores[k];
                check($sformatf("v%0d_k%0d_valid", i, k), cta_valid, exp_v);
                check($sformatf("v%0d_k%0d_x", i, k), cta_x, mx);
                check($sformatf("v%0d_k%0d_y", i, k), cta_y, my);
                check($sformatf("v%0d_k%0d_z", i, k), cta_z, mz);
                check($sformatf("v%0d_k%0d_id", i, k), cta_id, k);
                check($sformatf("v%0d_k%0d_done", i, k), done, 0);
                check($sformatf("v%0d_k%0d_lready", i, k), launch_ready, 0);
                if (k == 0) begin
                    check($sformatf("v%0d_param", i), cta_param, 32'hA000_0000 | 32'(i));
                    check($sformatf("v%0d_warps", i), cta_num_warps, 32'd6);
                    check($sformatf("v%0d_pc", i), cta_start_pc, 32'h400);
                    check($sformatf("v%0d_rmask", i), cta_remain_mask, 4'b0111);
                end
                if (mx == vecs[i].gx - 16'd1) begin
                    mx = '0;
                    if (my == vecs[i].gy - 16'd1) begin
                        my = '0;
                        mz = mz + 16'd1;
                    end else my = my + 16'd1;
                end else mx = mx + 16'd1;
                @(posedge clk); #1;
            end
            check($sformatf("v%0d_done_pulse", i), done, 1);
            check($sformatf("v%0d_done_busy", i), busy, 1);
            check($sformatf("v%0d_done_valid", i), cta_valid, 0);
            check($sformatf("v%0d_done_lready", i), launch_ready, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_post_done", i), done, 0);
            check($sformatf("v%0d_post_busy", i), busy, 0);
            check($sformatf("v%0d_post_lready", i), launch_ready, 1);
        end

        // Stall: core 1 holds off its first CTA for 5 cycles; other cores are ready but not targeted.
        apply_reset();
        cta_ready = 4'b1101;
        set_launch(16'd3, 16'd1, 16'd1, 4'b1010, 32'hDEAD_BEEF);
        launch_valid = 1'b1;
        @(posedge clk); #1;
        launch_valid = 1'b0;
        check("stall_valid0", cta_valid, 4'b0010);
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check($sformatf("stall_hold_valid%0d", s), cta_valid, 4'b0010);
            check($sformatf("stall_hold_x%0d", s), cta_x, 0);
            check($sformatf("stall_hold_id%0d", s), cta_id, 0);
            check($sformatf("stall_hold_param%0d", s), cta_param, 32'hDEAD_BEEF);
        end
        cta_ready = 4'b1111;
        @(posedge clk); #1;
        check("stall_valid1", cta_valid, 4'b1000);
        check("stall_x1", cta_x, 1);
        check("stall_id1", cta_id, 1);
        @(posedge clk); #1;
        check("stall_valid2", cta_valid, 4'b0010);
        check("stall_x2", cta_x, 2);
        check("stall_id2", cta_id, 2);
        @(posedge clk); #1;
        check("stall_done", done, 1);
        check("stall_done_valid", cta_valid, 0);

        // Abort while the 5th CTA is being handed over.
        apply_reset();
        set_launch(16'd4, 16'd2, 16'd2, 4'b1111, 32'h55);
        launch_valid = 1'b1;
        @(posedge clk); #1;
        launch_valid = 1'b0;
        hs_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            exp_v = 4'b0001 << k;
            check($sformatf("abort_valid%0d", k), cta_valid, exp_v);
            if ((cta_valid & cta_ready) != 4'b0000) hs_cnt++;
            @(posedge clk); #1;
        end
        check("abort_valid4", cta_valid, 4'b0001);
        check("abort_x4", cta_x, 0);
        check("abort_y4", cta_y, 1);
        check("abort_id4", cta_id, 4);
        if ((cta_valid & cta_ready) != 4'b0000) hs_cnt++;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_cta_count", hs_cnt, 5);
        check("abort_valid_off", cta_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done, 0);
        check("abort_lready", launch_ready, 1);
        @(posedge clk); #1;
        check("abort_no_done_later", done, 0);

        // Reset in the middle of a kernel, then a fresh launch starts at core 0.
        apply_reset();
        set_launch(16'd4, 16'd2, 16'd2, 4'b1111, 32'h77);
        launch_valid = 1'b1;
        @(posedge clk); #1;
        launch_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_pre_valid", cta_valid, 4'b0100);
        #2 reset = 1'b1;
        #1;
        check("mid_async_valid", cta_valid, 0);
        check("mid_async_busy", busy, 0);
        check("mid_async_lready", launch_ready, 1);
        #1 reset = 1'b0;
        set_launch(16'd2, 16'd1, 16'd1, 4'b1111, 32'h88);
        launch_valid = 1'b1;
        @(posedge clk); #1;
        launch_valid = 1'b0;
        check("mid_new_valid0", cta_valid, 4'b0001);
        check("mid_new_id0", cta_id, 0);
        check("mid_new_param", cta_param, 32'h88);
        @(posedge clk); #1;
        check("mid_new_valid1", cta_valid, 4'b0010);
        check("mid_new_id1", cta_id, 1);
        @(posedge clk); #1;
        check("mid_new_done", done, 1);

        // launch_valid held through a kernel: the second launch is accepted on the next IDLE cycle.
        apply_reset();
        set_launch(16'd2, 16'd1, 16'd1, 4'b1111, 32'h111);
        launch_valid = 1'b1;
        @(posedge clk); #1;
        set_launch(16'd1, 16'd1, 16'd1, 4'b1111, 32'h222);
        check("held_lready0", launch_ready, 0);
        check("held_valid0", cta_valid, 4'b0001);
        check("held_param0", cta_param, 32'h111);
        @(posedge clk); #1;
        check("held_lready1", launch_ready, 0);
        check("held_valid1", cta_valid, 4'b0010);
        @(posedge clk); #1;
        check("held_done", done, 1);
        check("held_lready_done", launch_ready, 0);
        @(posedge clk); #1;
        check("held_idle_lready", launch_ready, 1);
        check("held_idle_valid", cta_valid, 0);
        @(posedge clk); #1;
        launch_valid = 1'b0;
        check("held_second_valid", cta_valid, 4'b0100);
        check("held_second_param", cta_param, 32'h222);
        check("held_second_id", cta_id, 0);
        @(posedge clk); #1;
        check("held_second_done", done, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
